// File: rtl/mtsp_lmb_dma_if.sv
// Host-side bus bundle for mtsp_lmb_dma: command, write-source stream,
// read-sink stream and the LMB request/return port.
// MTSP_LMB_DMA_STRIDE_EN adds CMD_STRIDE.
`ifndef SIZE_LMB
`define SIZE_LMB 12
`endif

interface mtsp_lmb_dma_if #(
  parameter int LMB_AW = `SIZE_LMB,
  parameter int CNT_W  = 16
);
  logic              CMD_START;
  logic              CMD_WRITE;
  logic [LMB_AW-1:0] CMD_ADDR;
  logic [CNT_W-1:0]  CMD_COUNT;
`ifdef MTSP_LMB_DMA_STRIDE_EN
  logic [LMB_AW-1:0] CMD_STRIDE;
`endif
  logic              CMD_BUSY;
  logic              CMD_DONE;
  logic              WS_VALID;
  logic              WS_READY;
  logic [255:0]      WS_DATA;
  logic              RS_VALID;
  logic              RS_READY;
  logic [255:0]      RS_DATA;
  logic              LM_EN;
  logic              LM_WE;
  logic [LMB_AW-1:0] LM_ADDR;
  logic [255:0]      LM_WDATA;
  logic              LM_READY;
  logic [255:0]      LM_RDATA;
  logic              LM_VALID;

  // DMA engine side
  modport master (
`ifdef MTSP_LMB_DMA_STRIDE_EN
    input  CMD_STRIDE,
`endif
    input  CMD_START, CMD_WRITE, CMD_ADDR, CMD_COUNT,
    input  WS_VALID, WS_DATA, RS_READY, LM_READY, LM_RDATA, LM_VALID,
    output CMD_BUSY, CMD_DONE, WS_READY, RS_VALID, RS_DATA,
    output LM_EN, LM_WE, LM_ADDR, LM_WDATA
  );

  // Host / LMB side
  modport slave (
`ifdef MTSP_LMB_DMA_STRIDE_EN
    output CMD_STRIDE,
`endif
    output CMD_START, CMD_WRITE, CMD_ADDR, CMD_COUNT,
    output WS_VALID, WS_DATA, RS_READY, LM_READY, LM_RDATA, LM_VALID,
    input  CMD_BUSY, CMD_DONE, WS_READY, RS_VALID, RS_DATA,
    input  LM_EN, LM_WE, LM_ADDR, LM_WDATA
  );
endinterface

// File: rtl/mtsp_lmb_dma.sv
// mtsp_lmb_dma: block-transfer engine between host streams and one core's LMB.
// Writes stream words into the LMB or reads LMB words out to a stream; the
// LMB may withhold LM_READY while the core owns the port.
// Optional: MTSP_LMB_DMA_STRIDE_EN adds a per-command address stride.
`ifndef SIZE_LMB
`define SIZE_LMB 12
`endif

module mtsp_lmb_dma #(
  parameter int CORE_ID    = 0,
  parameter int LMB_AW     = `SIZE_LMB,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           CLK,
  input  logic           nRST,
  mtsp_lmb_dma_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Reject unusable configurations at elaboration time.
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (CORE_ID < 0)) begin : g_cfg_err
    $error("mtsp_lmb_dma: FIFO_DEPTH must be a power of 2 >= 2, CORE_ID >= 0");
  end

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t            state;
  logic [LMB_AW-1:0] addr;
  logic [LMB_AW-1:0] step;
  logic [CNT_W-1:0]  rem;
  logic [CW-1:0]     outst;
  logic              busy;
  logic              done;
  logic [CW-1:0]     fifo_cnt;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [255:0]      mem [FIFO_DEPTH];
  logic              lm_en;
  logic              accept;
  logic              push;
  logic              pop;

`ifdef MTSP_LMB_DMA_STRIDE_EN
  logic [LMB_AW-1:0] stride;
  assign step = stride;
`else
  assign step = LMB_AW'(1);
`endif

  // Request generation: writes follow the source stream, reads are
  // throttled so every issued read already owns a FIFO slot.
  always_comb begin
    lm_en = 1'b0;
    if (state == S_WRITE)
      lm_en = bus.WS_VALID;
    else if (state == S_READ)
      lm_en = (rem != '0) &&
              (({1'b0, fifo_cnt} + {1'b0, outst}) < (CW + 1)'(FIFO_DEPTH));
  end

  assign accept       = lm_en & bus.LM_READY;
  assign push         = bus.LM_VALID && (state == S_READ);
  assign pop          = (fifo_cnt != '0) && bus.RS_READY;

  assign bus.LM_EN    = lm_en;
  assign bus.LM_WE    = (state == S_WRITE);
  assign bus.LM_ADDR  = addr;
  assign bus.LM_WDATA = (state == S_WRITE) ? bus.WS_DATA : '0;
  assign bus.WS_READY = (state == S_WRITE) & bus.LM_READY;
  assign bus.RS_VALID = (fifo_cnt != '0);
  assign bus.RS_DATA  = (fifo_cnt != '0) ? mem[rd_ptr] : '0;
  assign bus.CMD_BUSY = busy;
  assign bus.CMD_DONE = done;

  // Command FSM: latches the command, walks addresses, tracks reads in flight.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= S_IDLE;
      addr  <= '0;
      rem   <= '0;
      outst <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef MTSP_LMB_DMA_STRIDE_EN
      stride <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (bus.CMD_START) begin
          addr  <= bus.CMD_ADDR;
          rem   <= bus.CMD_COUNT;
          outst <= '0;
`ifdef MTSP_LMB_DMA_STRIDE_EN
          stride <= bus.CMD_STRIDE;
`endif
          if (bus.CMD_COUNT == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            busy  <= 1'b1;
            state <= bus.CMD_WRITE ? S_WRITE : S_READ;
          end
        end
        S_WRITE: if (accept) begin
          addr <= addr + step;
          rem  <= rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_READ: begin
          if (accept) begin
            addr <= addr + step;
            rem  <= rem - CNT_W'(1);
          end
          outst <= outst + CW'(accept) - CW'(push);
          if ((rem == '0) && (outst == '0) && (fifo_cnt == '0)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read-return FIFO pointers and occupancy; contents are dropped on reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; never read while empty, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= bus.LM_RDATA;
  end
endmodule

// File: tb/tb_mtsp_lmb_dma.sv
// Directed, table-driven bench for mtsp_lmb_dma with a behavioural LMB
// (2-cycle read return) and a request-stability monitor.
module tb_mtsp_lmb_dma;
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  mtsp_lmb_dma_if #(.LMB_AW(8), .CNT_W(16)) bus ();
  mtsp_lmb_dma #(.CORE_ID(0), .LMB_AW(8), .CNT_W(16), .FIFO_DEPTH(4)) dut (
    .CLK(clk), .nRST(nrst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct {
    logic         we;
    logic [7:0]   addr;
    logic [255:0] data;
  } acc_t;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    int         cnt;
    logic [3:0] rdy_pat;
    int         rs_hold;
    int         restart_cyc;
    int         stride;
    int         exp_busy1;
    int         exp_first_en;
    int         exp_first_rs;
    int         done_lo;
    int         done_hi;
    int         exp_hold_acc;
    logic [7:0] exp_last;
  } vec_t;

  logic [255:0] lmem [256];
  acc_t         acc_q [$];

  // Behavioural LMB: logs accepted requests, returns read data 2 cycles later,
  // and checks that a stalled request is held unchanged.
  logic         v0 = 1'b0, acc_rd = 1'b0;
  logic [255:0] d0 = '0, rd_d = '0;
  logic         p_ok = 1'b0, p_en = 1'b0, p_rdy = 1'b0, p_we = 1'b0;
  logic [7:0]   p_addr = '0;
  logic [255:0] p_wd = '0;

  always @(negedge clk) begin
    if (nrst && p_ok && p_en && !p_rdy) begin
      chk("stall_en",    bus.LM_EN,    1'b1);
      chk("stall_we",    bus.LM_WE,    p_we);
      chk("stall_addr",  bus.LM_ADDR,  p_addr);
      chk("stall_wdata", bus.LM_WDATA, p_wd);
    end
    p_ok = nrst; p_en = bus.LM_EN; p_rdy = bus.LM_READY;
    p_we = bus.LM_WE; p_addr = bus.LM_ADDR; p_wd = bus.LM_WDATA;
    acc_rd = 1'b0;
    if (nrst && bus.LM_EN && bus.LM_READY) begin
      acc_q.push_back('{we: bus.LM_WE, addr: bus.LM_ADDR, data: bus.LM_WDATA});
      if (bus.LM_WE) lmem[bus.LM_ADDR] = bus.LM_WDATA;
      else begin
        acc_rd = 1'b1;
        rd_d   = lmem[bus.LM_ADDR];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    bus.LM_VALID = v0;
    bus.LM_RDATA = d0;
    v0 = acc_rd;
    d0 = rd_d;
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},  bus.CMD_BUSY, 1'b0);
    chk({tag, "_done"},  bus.CMD_DONE, 1'b0);
    chk({tag, "_lm_en"}, bus.LM_EN,    1'b0);
    chk({tag, "_lm_we"}, bus.LM_WE,    1'b0);
    chk({tag, "_addr"},  bus.LM_ADDR,  8'h00);
    chk({tag, "_wdata"}, bus.LM_WDATA, 256'h0);
    chk({tag, "_rsv"},   bus.RS_VALID, 1'b0);
    chk({tag, "_rsd"},   bus.RS_DATA,  256'h0);
    chk({tag, "_wsr"},   bus.WS_READY, 1'b0);
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    int ws_idx = 0, first_en = -1, first_rs = -1, done_cyc = -1, done_cnt = 0;
    int hold_acc = -1, last_acc = -1, c = 0;
    logic hold_en = 1'b0;
    bit fin = 1'b0;
    logic [255:0] rs_q [$];
    acc_q.delete();
    while (c < 100 && !fin) begin
      @(posedge clk); #1;
      bus.CMD_START = (c == 0) || (v.restart_cyc > 0 && c == v.restart_cyc);
      bus.CMD_WRITE = (c == 0) ? v.wr : !v.wr;
      bus.CMD_ADDR  = (c == 0) ? v.addr : 8'h99;
      bus.CMD_COUNT = (c == 0) ? 16'(v.cnt) : 16'd7;
`ifdef MTSP_LMB_DMA_STRIDE_EN
      bus.CMD_STRIDE = (c == 0) ? 8'(v.stride) : 8'd5;
`endif
      bus.LM_READY = v.rdy_pat[c % 4];
      bus.WS_VALID = v.wr && (ws_idx < v.cnt);
      bus.WS_DATA  = 256'(32'hA0 + ws_idx);
      bus.RS_READY = (c >= v.rs_hold);
      @(negedge clk); #1;
      if (c == 1) chk({tag, "_busy1"}, bus.CMD_BUSY, v.exp_busy1[0]);
      chk({tag, "_ws_ready"}, bus.WS_READY, v.wr & bus.CMD_BUSY & bus.LM_READY);
      if (bus.LM_EN && first_en < 0) first_en = c;
      if (bus.RS_VALID && first_rs < 0) first_rs = c;
      if (bus.LM_EN && bus.LM_READY) last_acc = c;
      if (bus.WS_VALID && bus.WS_READY) ws_idx++;
      if (bus.RS_VALID && bus.RS_READY) rs_q.push_back(bus.RS_DATA);
      if (v.rs_hold > 0 && c == v.rs_hold - 1) begin
        hold_acc = acc_q.size();
        hold_en  = bus.LM_EN;
      end
      if (bus.CMD_DONE) begin
        done_cnt++;
        done_cyc = c;
        fin = 1'b1;
      end
      c++;
    end
    if (!fin) chk({tag, "_timeout"}, 1'b0, 1'b1);
    bus.CMD_START = 1'b0;
    bus.WS_VALID  = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      @(negedge clk); #1;
      chk({tag, "_tail_busy"}, bus.CMD_BUSY, 1'b0);
      chk({tag, "_tail_en"},   bus.LM_EN,    1'b0);
      if (bus.CMD_DONE) done_cnt++;
    end
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_cyc"},
        (done_cyc >= v.done_lo && done_cyc <= v.done_hi) ? v.done_lo : done_cyc, v.done_lo);
    chk({tag, "_first_en"}, first_en, v.exp_first_en);
    chk({tag, "_first_rs"}, first_rs, v.exp_first_rs);
    chk({tag, "_n_acc"}, acc_q.size(), v.cnt);
    foreach (acc_q[i]) begin
      chk($sformatf("%s_acc%0d_addr", tag, i), acc_q[i].addr, 8'(v.addr + i * v.stride));
      chk($sformatf("%s_acc%0d_we", tag, i), acc_q[i].we, v.wr);
      if (v.wr) chk($sformatf("%s_acc%0d_data", tag, i), acc_q[i].data, 256'(32'hA0 + i));
    end
    if (acc_q.size() > 0) chk({tag, "_last_addr"}, acc_q[acc_q.size() - 1].addr, v.exp_last);
    if (v.wr) chk({tag, "_done_gap"}, done_cyc - last_acc, 1);
    else begin
      chk({tag, "_n_rs"}, rs_q.size(), v.cnt);
      foreach (rs_q[i])
        chk($sformatf("%s_rs%0d", tag, i), rs_q[i], 256'(32'hD000_0000 + 8'(v.addr + i)));
    end
    if (v.rs_hold > 0) begin
      chk({tag, "_hold_acc"}, hold_acc, v.exp_hold_acc);
      chk({tag, "_hold_en"}, hold_en, 1'b0);
    end
  endtask

  vec_t vt [7];
  vec_t vx;

  initial begin
    // wr addr cnt pat hold restart stride busy1 first_en first_rs done_lo done_hi hold_acc last
    vt[0] = '{1'b1, 8'h10, 4, 4'hF, 0,  5, 1, 1,  1, -1,  5,  5, 0, 8'h13};
    vt[1] = '{1'b0, 8'h20, 8, 4'hF, 10, 3, 1, 1,  1,  4, 19, 40, 4, 8'h27};
    vt[2] = '{1'b1, 8'h30, 6, 4'h9, 0,  0, 1, 1,  1, -1, 13, 13, 0, 8'h35};
    vt[3] = '{1'b0, 8'hFF, 3, 4'h6, 0,  0, 1, 1,  1,  4, 10, 10, 0, 8'h01};
    vt[4] = '{1'b1, 8'hFE, 4, 4'hF, 0,  0, 1, 1,  1, -1,  5,  5, 0, 8'h01};
    vt[5] = '{1'b0, 8'h60, 1, 4'hF, 0,  0, 1, 1,  1,  4,  6,  6, 0, 8'h60};
    vt[6] = '{1'b0, 8'h05, 0, 4'hF, 0,  0, 1, 0, -1, -1,  1,  2, 0, 8'h00};

    for (int i = 0; i < 256; i++) lmem[i] = 256'(32'hD000_0000 + i);

    nrst = 1'b0;
    bus.CMD_START = 1'b0; bus.CMD_WRITE = 1'b0; bus.CMD_ADDR = '0; bus.CMD_COUNT = '0;
`ifdef MTSP_LMB_DMA_STRIDE_EN
    bus.CMD_STRIDE = 8'd1;
`endif
    bus.WS_VALID = 1'b0; bus.WS_DATA = '0; bus.RS_READY = 1'b0; bus.LM_READY = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk_reset("rst");
    @(posedge clk); #1;
    nrst = 1'b1;

    for (int i = 0; i < 7; i++) run_cmd(vt[i], $sformatf("v%0d", i));

    // Reset in the middle of a read with two requests outstanding.
    @(posedge clk); #1;
    bus.CMD_START = 1'b1; bus.CMD_WRITE = 1'b0; bus.CMD_ADDR = 8'h40; bus.CMD_COUNT = 16'd8;
    bus.LM_READY = 1'b1; bus.RS_READY = 1'b0;
    @(posedge clk); #1;
    bus.CMD_START = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk); #1;
    chk_reset("midrst");
    repeat (4) begin
      @(posedge clk); #1;
      @(negedge clk); #1;
      chk("midrst_stale_rsv", bus.RS_VALID, 1'b0);
      chk("midrst_stale_busy", bus.CMD_BUSY, 1'b0);
    end
    vx = '{1'b0, 8'h50, 2, 4'hF, 0, 0, 1, 1, 1, 4, 7, 7, 0, 8'h51};
    run_cmd(vx, "after_rst");

`ifdef MTSP_LMB_DMA_STRIDE_EN
    vx = '{1'b1, 8'h00, 3, 4'hF, 0, 0, 3, 1, 1, -1, 4, 4, 0, 8'h06};
    run_cmd(vx, "stride3");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
